// File: rtl/fifo_sram_sc.sv
// Single-clock FIFO: 2-port SRAM (1-cycle read) feeding a 2-entry output buffer, capacity DEPTH+2.
// Define FIFO_SRAM_SC_PARITY_EN to store an even-parity bit per entry and flag rd_perr on mismatch.
module fifo_sram_sc #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [$clog2(DEPTH+3)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         rd_perr
);

  localparam int CAP = DEPTH + 2;
  localparam int CW  = $clog2(DEPTH + 3);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
`ifdef FIFO_SRAM_SC_PARITY_EN
  localparam int SW  = WIDTH + 1;
`else
  localparam int SW  = WIDTH;
`endif

  logic [SW-1:0] mem_q [DEPTH];
  logic [SW-1:0] sram_rdata_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic [SW-1:0] ob0_q, ob0_d, ob1_q, ob1_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_fire, rd_fire, sram_re, sram_we, sram_empty;
  logic [1:0]    ob_keep;
  logic [SW-1:0] wr_word;

`ifdef FIFO_SRAM_SC_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
  assign rd_perr = rd_valid & (^ob0_q);
`else
  assign wr_word = wr_data;
  assign rd_perr = 1'b0;
`endif

  assign wr_ready     = (count_q != CW'(CAP));
  assign rd_valid     = (ob_cnt_q != 2'd0);
  assign rd_data      = ob0_q[WIDTH-1:0];
  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

  // A read is issued only if the buffer can absorb it next edge, so the SRAM
  // output never needs holding and buffer + in-flight never exceeds two.
  always_comb begin
    wr_fire    = wr_valid & wr_ready;
    rd_fire    = rd_valid & rd_ready;
    sram_empty = (wr_ptr_q == rd_ptr_q);
    ob_keep    = ob_cnt_q - {1'b0, rd_fire};
    sram_re    = !sram_empty && (({1'b0, inflight_q} + ob_keep) < 2'd2) && !flush;
    sram_we    = wr_fire && !flush;

    wr_ptr_d   = wr_ptr_q + PW'(sram_we);
    rd_ptr_d   = rd_ptr_q + PW'(sram_re);
    inflight_d = sram_re;
    ob_cnt_d   = ob_keep + {1'b0, inflight_q};
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    if (rd_fire) ob0_d = ob1_q;
    if (inflight_q) begin
      if (ob_keep == 2'd0) ob0_d = sram_rdata_q;
      else                 ob1_d = sram_rdata_q;
    end

    count_d = count_q;
    if (wr_fire && !rd_fire)      count_d = count_q + CW'(1);
    else if (!wr_fire && rd_fire) count_d = count_q - CW'(1);

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
      ob_cnt_d   = 2'd0;
      ob0_d      = '0;
      ob1_d      = '0;
      count_d    = '0;
    end
  end

  // SRAM array and its read-data register carry no reset.
  always_ff @(posedge clk) begin
    if (sram_we) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    if (sram_re) sram_rdata_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      ob0_q      <= '0;
      ob1_q      <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_sram_sc.sv
// Directed self-checking bench for fifo_sram_sc (WIDTH=32, DEPTH=16).
module tb_fifo_sram_sc;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 3);

  logic             clk = 1'b0;
  logic             rstb, flush, wr_valid, wr_ready, rd_valid, rd_ready;
  logic             almost_full, almost_empty, rd_perr;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic [CW-1:0]    count;
  int               num_checks = 0;
  int               num_errors = 0;

  always #5 clk = ~clk;

  fifo_sram_sc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstb(rstb), .flush(flush),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .rd_perr(rd_perr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [WIDTH-1:0] wd, input logic rr,
                               input logic fl, input logic rb);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    rstb     = rb;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted, sent, rcv;
    logic w_fire, r_fire;

    applyStimulus(0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();
    checkOutput("rst_count", count, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_wr_ready", wr_ready, 1);
    checkOutput("rst_almost_full", almost_full, 0);
    checkOutput("rst_almost_empty", almost_empty, 1);
    checkOutput("rst_rd_perr", rd_perr, 0);
    checkOutput("rst_rd_data", rd_data, 0);

    // Single write: rd_valid appears two edges after the write edge.
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    applyStimulus(1, 32'hA5, 0, 0, 1);
    stepCycle();
    checkOutput("lat_n_valid", rd_valid, 0);
    checkOutput("lat_n_count", count, 1);
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("lat_n1_valid", rd_valid, 0);
    stepCycle();
    checkOutput("lat_n2_valid", rd_valid, 1);
    checkOutput("lat_n2_data", rd_data, 32'hA5);
    checkOutput("lat_n2_count", count, 1);
    checkOutput("lat_n2_almost_empty", almost_empty, 1);
    applyStimulus(0, 0, 1, 0, 1);
    stepCycle();
    checkOutput("lat_pop_valid", rd_valid, 0);
    checkOutput("lat_pop_count", count, 0);

    // Fill past capacity with the consumer stalled.
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 32'(100 + i), 0, 0, 1);
      if (wr_ready) accepted++;
      stepCycle();
    end
    checkOutput("fill_accepted", accepted, 18);
    checkOutput("fill_wr_ready", wr_ready, 0);
    checkOutput("fill_count", count, 18);
    checkOutput("fill_almost_full", almost_full, 1);
    checkOutput("fill_almost_empty", almost_empty, 0);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, 0, 1, 0, 1);
      checkOutput("drain_valid", rd_valid, 1);
      checkOutput("drain_data", rd_data, 32'(100 + i));
      stepCycle();
    end
    checkOutput("drain_end_valid", rd_valid, 0);
    checkOutput("drain_end_count", count, 0);
    checkOutput("drain_end_wr_ready", wr_ready, 1);

    // Streaming: one word per cycle across many pointer wraps.
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 1100 && rcv < 1000; cyc++) begin
      applyStimulus(sent < 1000, 32'(sent), 1, 0, 1);
      w_fire = (sent < 1000) && wr_ready;
      r_fire = rd_valid;
      if (rd_valid) checkOutput("stream_data", rd_data, 32'(rcv));
      else if (rcv > 0) checkOutput("stream_gap", rd_valid, 1);
      stepCycle();
      if (w_fire) sent++;
      if (r_fire) rcv++;
      if (rcv > 0 && sent < 1000) checkOutput("stream_count", count, 3);
    end
    checkOutput("stream_total", rcv, 1000);
    checkOutput("stream_perr", rd_perr, 0);
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("stream_end_count", count, 0);

    // Flush with a coincident write and read.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'(200 + i), 0, 0, 1);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    checkOutput("flush_pre_count", count, 10);
    applyStimulus(1, 32'hDEADBEEF, 1, 1, 1);
    stepCycle();
    checkOutput("flush_count", count, 0);
    checkOutput("flush_rd_valid", rd_valid, 0);
    checkOutput("flush_wr_ready", wr_ready, 1);
    checkOutput("flush_almost_empty", almost_empty, 1);
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("flush_no_ghost", rd_valid, 0);
    checkOutput("flush_idle_count", count, 0);
    applyStimulus(1, 32'd300, 0, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    stepCycle();
    checkOutput("flush_after_valid", rd_valid, 1);
    checkOutput("flush_after_data", rd_data, 32'd300);
    applyStimulus(0, 0, 1, 0, 1);
    stepCycle();
    checkOutput("flush_after_pop", rd_valid, 0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 32'(400 + i), 0, 0, 1);
      stepCycle();
    end
    checkOutput("mid_pre_count", count, 7);
    applyStimulus(1, 32'h999, 1, 0, 0);
    stepCycle();
    checkOutput("mid_rst_count", count, 0);
    checkOutput("mid_rst_rd_valid", rd_valid, 0);
    checkOutput("mid_rst_wr_ready", wr_ready, 1);
    checkOutput("mid_rst_rd_data", rd_data, 0);
    checkOutput("mid_rst_almost_empty", almost_empty, 1);
    applyStimulus(1, 32'd500, 0, 0, 1);
    stepCycle();
    applyStimulus(1, 32'd501, 0, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    stepCycle();
    checkOutput("mid_post_count", count, 2);
    checkOutput("mid_post_valid", rd_valid, 1);
    checkOutput("mid_post_data0", rd_data, 32'd500);
    applyStimulus(0, 0, 1, 0, 1);
    stepCycle();
    checkOutput("mid_post_data1", rd_data, 32'd501);
    stepCycle();
    checkOutput("mid_post_empty", rd_valid, 0);
    checkOutput("mid_post_end_count", count, 0);

`ifdef FIFO_SRAM_SC_PARITY_EN
    // Corrupt the first stored word before it is read out of the SRAM.
    applyStimulus(0, 0, 0, 1, 1);
    stepCycle();
    applyStimulus(1, 32'h0F, 0, 0, 1);
    stepCycle();
    dut.mem_q[0] = dut.mem_q[0] ^ 33'd1;
    applyStimulus(1, 32'h33, 0, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    stepCycle();
    checkOutput("perr_bad_valid", rd_valid, 1);
    checkOutput("perr_bad_data", rd_data, 32'h0E);
    checkOutput("perr_bad_flag", rd_perr, 1);
    applyStimulus(0, 0, 1, 0, 1);
    stepCycle();
    checkOutput("perr_good_data", rd_data, 32'h33);
    checkOutput("perr_good_flag", rd_perr, 0);
    stepCycle();
    checkOutput("perr_empty_flag", rd_perr, 0);
`else
    applyStimulus(1, 32'h0F, 0, 0, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 1);
    stepCycle();
    stepCycle();
    checkOutput("perr_off_valid", rd_valid, 1);
    checkOutput("perr_off_flag", rd_perr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/fifo_sram_sc.md
FIFO_SRAM_SC -- requirements
Module: fifo_sram_sc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, SRAM entries (power of 2, >=4).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH, almost-full threshold (1..DEPTH+2).
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH+1).
REQ-005 SHALL have port clk  in  1  single clock; all logic on posedge clk.
REQ-006 SHALL have port rstb  in  1  reset; synchronous, active-low.
REQ-007 SHALL have port flush  in  1  synchronous discard of all contents.
REQ-008 SHALL have port wr_data  in  WIDTH  write payload.
REQ-009 SHALL have port wr_valid  in  1  write request.
REQ-010 SHALL have port wr_ready  out  1  space available.
REQ-011 SHALL have port rd_data  out  WIDTH  head-of-FIFO payload.
REQ-012 SHALL have port rd_valid  out  1  rd_data valid.
REQ-013 SHALL have port rd_ready  in  1  consumer accepts.
REQ-014 SHALL have port count  out  $clog2(DEPTH+3)  entries held.
REQ-015 SHALL have ports almost_full and almost_empty  out  1  threshold flags.
REQ-016 SHALL have port rd_perr  out  1  parity error on current rd_data.

Function
REQ-017 SHALL store entries in a 2-port synchronous SRAM (DEPTH entries, 1-cycle read latency) plus a 2-entry registered output buffer; total capacity CAP = DEPTH+2.
REQ-018 SHALL accept a write on any edge with wr_valid & wr_ready, and deliver a read on any edge with rd_valid & rd_ready.
REQ-019 SHALL drive wr_ready = (count != CAP), from registered state only, with no combinational path from rd_ready.
REQ-020 SHALL hold rd_data and rd_valid stable while rd_valid & !rd_ready.
REQ-021 SHALL present rd_valid on the second edge after the edge that writes into an empty FIFO (first-word latency 2), with no bypass path.
REQ-022 SHALL sustain one write and one read per cycle indefinitely once rd_valid is high and rd_ready is held at 1.
REQ-023 SHALL preserve strict FIFO order across pointer wrap-around; pointers carry one extra roll-over bit.
REQ-024 SHALL update count by +1 on write only, -1 on read only, and 0 on simultaneous write and read.
REQ-025 SHALL drive almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL), both decoded from registered count.
REQ-026 SHALL, when flush=1, clear pointers, output buffer and in-flight SRAM read by the next edge: count=0, rd_valid=0, wr_ready=1; a write or read coincident with flush is discarded.
REQ-027 SHALL ignore wr_valid while wr_ready=0, with no state change and no SRAM write.

Reset
REQ-028 SHALL on an edge with rstb=0 set count=0, rd_valid=0, wr_ready=1, almost_full=0, almost_empty=1, rd_perr=0, rd_data=0, and discard all pointers and in-flight reads.
REQ-029 SHALL let reset override flush and all handshakes, including when asserted mid-burst; SRAM contents need not be cleared.

Configuration
REQ-030 SHALL, with macro FIFO_SRAM_SC_PARITY_EN defined, store WIDTH+1 bits per entry (even parity over wr_data) and assert rd_perr together with rd_valid when the stored parity mismatches rd_data.
REQ-031 SHALL, without FIFO_SRAM_SC_PARITY_EN, use WIDTH-bit SRAM and tie rd_perr to 0; the port list is identical in both builds.

Verification
REQ-032 Reset, then one write 0xA5 at edge N with rd_ready=0 -> rd_valid=1 and rd_data=0xA5 after edge N+2; count=1.
REQ-033 DEPTH=16, rd_ready=0, write 20 values -> wr_ready=0 after 18 accepts, count=18, almost_full=1; then drain all 18 in order with no gaps.
REQ-034 Continuous write and read of 1000 incrementing values with rd_ready=1 -> 1 word/cycle after latency 2, no loss or reorder across wraps, count stable.
REQ-035 With 10 entries held, assert flush coincident with wr_valid and rd_ready -> next edge count=0, rd_valid=0; the coincident write value never appears at the output.
REQ-036 Assert rstb=0 for one cycle mid-burst with count=7 -> count=0, rd_valid=0, wr_ready=1; subsequent traffic is correct.
REQ-037 With FIFO_SRAM_SC_PARITY_EN, force-flip one stored data bit -> rd_perr=1 only while that entry is presented; without the macro, rd_perr=0 always.
